// File: rtl/seq_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width and FSM state encoding.
package seq_sub_pkg;

  localparam int unsigned SEQ_SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - b_in, b_out set when the bit borrows.
module full_subtractor (
  output logic b_out,
  output logic d,
  input  logic a,
  input  logic b,
  input  logic b_in
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/seq_subtractor4b.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first.
// Optional signed-overflow output v is built when SEQ_SUB_OVF_EN is defined.
module seq_subtractor4b
  import seq_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             busy,
  output logic             done
`ifdef SEQ_SUB_OVF_EN
  ,
  output logic             v
`endif
);

  // One extra counter bit so the final increment to WIDTH never wraps.
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             fs_d;
  logic             fs_bo;
`ifdef SEQ_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_fs (
    .b_out (fs_bo),
    .d     (fs_d),
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .b_in  (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      v      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= b_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
`ifdef SEQ_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          borrow <= fs_bo;
          res_sr <= {fs_d, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // fs_d is the MSB of the result on this final edge.
            d     <= {fs_d, res_sr[WIDTH-1:1]};
            b_out <= fs_bo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
`ifdef SEQ_SUB_OVF_EN
            v     <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor4b.sv
// Scoreboard bench for seq_subtractor4b; builds with or without SEQ_SUB_OVF_EN.
module tb_seq_subtractor4b;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    int           cyc;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic [W-1:0] d;
  logic         b_out;
  logic         busy;
  logic         done;
`ifdef SEQ_SUB_OVF_EN
  logic         v;
`endif

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           busy_cnt = 0;
  logic [W-1:0] hold_d   = '0;
  logic         hold_bo  = 1'b0;

  seq_subtractor4b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .d     (d),
    .b_out (b_out),
    .busy  (busy),
    .done  (done)
`ifdef SEQ_SUB_OVF_EN
    ,
    .v     (v)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also checks outputs hold during RUN.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      hold_d   = '0;
      hold_bo  = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check("d_hold_in_run", int'(d), int'(hold_d));
        check("bout_hold_in_run", int'(b_out), int'(hold_bo));
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_d"}, int'(d), int'(e.d));
          check({e.tag, "_bout"}, int'(b_out), int'(e.bo));
`ifdef SEQ_SUB_OVF_EN
          check({e.tag, "_v"}, int'(v), int'(e.v));
`endif
          check({e.tag, "_latency"}, cyc, e.cyc);
          check({e.tag, "_busy_cycles"}, busy_cnt, W);
          hold_d  = e.d;
          hold_bo = e.bo;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic push(input logic [W-1:0] ed, input logic ebo, input logic ev, input string tag);
    exp_t e;
    e.d = ed; e.bo = ebo; e.v = ev; e.cyc = cyc + W; e.tag = tag;
    sb.push_back(e);
  endtask

  // Issue one request at the next edge; returns aligned so a following call is accepted.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] ed, input logic ebo, input logic ev, input string tag);
    a = ia; b = ib; b_in = ibin; start = 1'b1;
    @(posedge clk); #1;
    push(ed, ebo, ev, tag);
    start = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W:0] wide;
    logic [W-1:0] md;
    logic mbo, mv;
    int wait_cyc;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_d", int'(d), 0);
    check("reset_bout", int'(b_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
`ifdef SEQ_SUB_OVF_EN
    check("reset_v", int'(v), 0);
`endif
    rst_n = 1'b1;

    // Directed vectors: a, b, b_in -> d, b_out, v (hand-computed).
    run_op(4'h7, 4'h5, 1'b0, 4'h2, 1'b0, 1'b0, "7m5");
    run_op(4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0, "3m5");
    run_op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, "0m0b1");
    run_op(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, "8m1");
    run_op(4'h2, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0, "2m1");
    run_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, "FmFb1");
    run_op(4'h0, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0, "0mF");
    run_op(4'h7, 4'h8, 1'b0, 4'hF, 1'b1, 1'b1, "7m8");

    // start re-pulsed with a=9 during RUN must be ignored.
    a = 4'h7; b = 4'h5; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    push(4'h2, 1'b0, 1'b0, "ignore_start");
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 4'h9;
    @(posedge clk); #1;
    start = 1'b0; a = 4'h0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in cycle 2 of RUN: outputs clear at once, no done for this request.
    a = 4'h7; b = 4'h5; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_d", int'(d), 0);
    check("midrun_reset_bout", int'(b_out), 0);
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(4'h6, 4'h6, 1'b0, 4'h0, 1'b0, 1'b0, "6m6_after_reset");

    // Exhaustive sweep with start held high: one accept every W+2 edges.
    for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
      a    = W'(i >> (W + 1));
      b    = W'(i >> 1);
      b_in = i[0];
      start = 1'b1;
      @(posedge clk); #1;
      wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, b_in};
      md   = wide[W-1:0];
      mbo  = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, b_in}));
      mv   = (a[W-1] != b[W-1]) && (md[W-1] != a[W-1]);
      push(md, mbo, mv, "sweep");
      if (i == (1 << (2 * W + 1)) - 1) start = 1'b0;
      repeat (W + 1) @(posedge clk);
      #1;
    end
    start = 1'b0;

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 50) begin
      @(posedge clk);
      wait_cyc++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
